// File: rtl/sum_input_sequencer.sv
// sum_input_sequencer
// Initiator-side sequencer for the single-operand function evaluator and the
// float adder. It takes an operand pair (x1, x2), runs the evaluator once per
// operand and adds the two results with the adder. The sum is returned on a
// valid/ready output. If a unit stops responding, the sequencer returns a
// quiet NaN with out_timeout set.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | in_ready high, waiting for an operand pair
// START1 | fn_start pulse with fn_data = x1, wait counter cleared
// WAIT1  | counting; capture f1 once done is qualified (cnt >= MIN_LAT)
// START2 | fn_start pulse with fn_data = x2, wait counter cleared
// WAIT2  | counting; capture f2 once done is qualified
// ADD    | add_enable held with f1/f2 on the adder; capture the sum
// HOLD   | out_valid held until the host takes the sum (or the abort NaN)

module sum_input_sequencer #(
   parameter int MIN_LAT = 4,
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_x1,
   input  logic [31:0] in_x2,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_sum,
   output logic        out_timeout,
   output logic        fn_start,
   output logic [31:0] fn_data,
   input  logic [31:0] fn_result,
   input  logic        fn_done,
   output logic        add_enable,
   output logic [31:0] add_dataa,
   output logic [31:0] add_datab,
   input  logic [31:0] add_result,
   input  logic        add_done
);

   localparam logic [CNT_W-1:0] MIN_LAT_C = CNT_W'(MIN_LAT);
   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
   localparam logic [31:0]      QNAN      = 32'h7FC0_0000;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START1,
      S_WAIT1,
      S_START2,
      S_WAIT2,
      S_ADD,
      S_HOLD
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [31:0]      x2_q;
   logic [31:0]      f1;
   logic [31:0]      f2;

   logic lat_ok;
   logic fn_accept;
   logic add_accept;
   logic cnt_expired;

   // done levels are only trusted after MIN_LAT cycles, which hides a done
   // still held high from the previous run
   assign lat_ok      = (cnt >= MIN_LAT_C);
   assign fn_accept   = lat_ok && fn_done;
   assign add_accept  = lat_ok && add_done;
   assign cnt_expired = (cnt == TIMEOUT_C);

   assign in_ready  = (state == S_IDLE);
   assign add_dataa = f1;
   assign add_datab = f2;

   // sequencer state, wait counter and all registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         cnt         <= '0;
         x2_q        <= '0;
         f1          <= '0;
         f2          <= '0;
         fn_start    <= 1'b0;
         fn_data     <= '0;
         add_enable  <= 1'b0;
         out_valid   <= 1'b0;
         out_sum     <= '0;
         out_timeout <= 1'b0;
      end else begin
         fn_start <= 1'b0;
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  x2_q     <= in_x2;
                  fn_data  <= in_x1;
                  fn_start <= 1'b1;
                  state    <= S_START1;
               end
            end
            S_START1: begin
               cnt   <= '0;
               state <= S_WAIT1;
            end
            S_WAIT1: begin
               if (fn_accept) begin
                  f1       <= fn_result;
                  fn_data  <= x2_q;
                  fn_start <= 1'b1;
                  state    <= S_START2;
               end else if (cnt_expired) begin
                  out_valid   <= 1'b1;
                  out_timeout <= 1'b1;
                  out_sum     <= QNAN;
                  state       <= S_HOLD;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            S_START2: begin
               cnt   <= '0;
               state <= S_WAIT2;
            end
            S_WAIT2: begin
               if (fn_accept) begin
                  f2         <= fn_result;
                  add_enable <= 1'b1;
                  cnt        <= '0;
                  state      <= S_ADD;
               end else if (cnt_expired) begin
                  out_valid   <= 1'b1;
                  out_timeout <= 1'b1;
                  out_sum     <= QNAN;
                  state       <= S_HOLD;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            S_ADD: begin
               if (add_accept) begin
                  add_enable <= 1'b0;
                  out_sum    <= add_result;
                  out_valid  <= 1'b1;
                  state      <= S_HOLD;
               end else if (cnt_expired) begin
                  add_enable  <= 1'b0;
                  out_valid   <= 1'b1;
                  out_timeout <= 1'b1;
                  out_sum     <= QNAN;
                  state       <= S_HOLD;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            S_HOLD: begin
               if (out_ready) begin
                  out_valid   <= 1'b0;
                  out_timeout <= 1'b0;
                  state       <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sum_input_sequencer.sv
// Bench for sum_input_sequencer: behavioural evaluator/adder responders, a
// transaction-level model checked every cycle, and directed literal checks.
`timescale 1ns/1ps

module tb_sum_input_sequencer;

   localparam int MIN_LAT = 4;
   localparam int TIMEOUT = 255;
   localparam int CNT_W   = 8;
   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_x1, in_x2;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_sum;
   logic        out_timeout;
   logic        fn_start;
   logic [31:0] fn_data;
   logic [31:0] fn_result;
   logic        fn_done;
   logic        add_enable;
   logic [31:0] add_dataa, add_datab;
   logic [31:0] add_result;
   logic        add_done;

   always #5 clk = ~clk;

   sum_input_sequencer #(.MIN_LAT(MIN_LAT), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_x1(in_x1), .in_x2(in_x2),
      .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
      .out_timeout(out_timeout),
      .fn_start(fn_start), .fn_data(fn_data), .fn_result(fn_result), .fn_done(fn_done),
      .add_enable(add_enable), .add_dataa(add_dataa), .add_datab(add_datab),
      .add_result(add_result), .add_done(add_done)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // evaluator behaviour: 1.0 -> 3.0, 2.0 -> 5.0, anything else rotated
   function automatic logic [31:0] f_model(input logic [31:0] x);
      if (x == 32'h3F80_0000) return 32'h4040_0000;
      if (x == 32'h4000_0000) return 32'h40A0_0000;
      return {x[30:0], x[31]};
   endfunction

   // adder behaviour: 3.0 + 5.0 = 8.0, anything else an arbitrary mix
   function automatic logic [31:0] add_model(input logic [31:0] a, input logic [31:0] b);
      if (a == 32'h4040_0000 && b == 32'h40A0_0000) return 32'h4100_0000;
      return a ^ {b[15:0], b[31:16]};
   endfunction

   // ---------------- responders ----------------
   int ev_mode = 0;   // 0 normal, 1 stale done, 2 never done, 3 done only before MIN_LAT
   int ev_lat  = 20;
   int add_lat = 5;
   int ev_cnt, ad_cnt;
   logic ev_pend, ad_busy;
   logic [31:0] ev_x;

   initial begin
      fn_done = 1'b0; fn_result = '0; ev_pend = 1'b0; ev_cnt = 0; ev_x = '0;
      forever begin
         @(negedge clk);
         if (fn_start) begin
            ev_x = fn_data; ev_cnt = 0; ev_pend = 1'b1;
            case (ev_mode)
               0: begin
                  if (ev_lat == 0) begin
                     fn_done = 1'b1; fn_result = f_model(ev_x); ev_pend = 1'b0;
                  end else fn_done = 1'b0;
               end
               1, 3: begin fn_done = 1'b1; fn_result = 32'hDEAD_BEEF; end
               default: begin fn_done = 1'b0; fn_result = 32'hDEAD_BEEF; ev_pend = 1'b0; end
            endcase
         end else if (ev_pend) begin
            ev_cnt++;
            // a value set here is sampled in the DUT cycle with cnt == ev_cnt-1
            if (ev_mode == 0 && ev_cnt == ev_lat) begin
               fn_done = 1'b1; fn_result = f_model(ev_x); ev_pend = 1'b0;
            end else if (ev_mode == 1 && ev_cnt == MIN_LAT + 1) begin
               fn_result = f_model(ev_x); ev_pend = 1'b0;
            end else if (ev_mode == 3 && ev_cnt == MIN_LAT + 1) begin
               fn_done = 1'b0; ev_pend = 1'b0;
            end
         end
      end
   end

   initial begin
      add_done = 1'b0; add_result = '0; ad_busy = 1'b0; ad_cnt = 0;
      forever begin
         @(negedge clk);
         if (!add_enable) begin
            add_done = 1'b0; ad_busy = 1'b0;
         end else if (!ad_busy) begin
            ad_busy = 1'b1; ad_cnt = 0;
            if (add_lat == 0) begin
               add_done = 1'b1; add_result = add_model(add_dataa, add_datab);
            end else add_done = 1'b0;
         end else begin
            ad_cnt++;
            if (ad_cnt == add_lat) begin
               add_done = 1'b1; add_result = add_model(add_dataa, add_datab);
            end
         end
      end
   end

   // ---------------- transaction model and per-cycle compare ----------------
   logic next_exp_to = 1'b0;
   int   cyc = 0;
   int   n_tx = 0;
   logic busy = 1'b0;
   logic [31:0] tx_x1, tx_x2;
   logic tx_to;
   logic p_in_ready = 1'b0, p_out_valid = 1'b0, p_fn_start = 1'b0;

   int          t_acc [16], t_st1 [16], t_st2 [16], t_ov [16], n_st [16];
   logic [31:0] d1 [16], d2 [16], rec_a [16], rec_b [16], rec_sum [16];
   logic        rec_to [16], add_seen [16], ov_rec [16];

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         begin
            logic acc, hs;
            int   c;
            acc = !reset && p_in_ready && in_valid;
            hs  = !reset && p_out_valid && out_ready;
            if (reset) busy = 1'b0;
            else if (acc) begin
               busy = 1'b1; tx_x1 = in_x1; tx_x2 = in_x2; tx_to = next_exp_to;
               c = n_tx % 16;
               t_acc[c] = cyc; n_st[c] = 0; add_seen[c] = 1'b0; ov_rec[c] = 1'b0;
               t_st1[c] = 0; t_st2[c] = 0; t_ov[c] = 0;
               n_tx++;
            end else if (hs) busy = 1'b0;
            c = (n_tx + 15) % 16;

            check("in_ready", in_ready, !busy);
            if (reset) begin
               check("rst_fn_start", fn_start, 1'b0);
               check("rst_add_enable", add_enable, 1'b0);
               check("rst_out_valid", out_valid, 1'b0);
            end
            if (fn_start && p_fn_start) check("fn_start_single", 32'd2, 32'd1);
            if (fn_start) begin
               check("fn_start_busy", busy, 1'b1);
               if (busy) begin
                  n_st[c]++;
                  check("fn_start_count", (n_st[c] <= 2), 1'b1);
                  if (n_st[c] == 1) begin
                     t_st1[c] = cyc; d1[c] = fn_data;
                  end else begin
                     t_st2[c] = cyc; d2[c] = fn_data;
                  end
               end
            end
            if (busy && n_st[c] >= 1)
               check("fn_data", fn_data, (n_st[c] >= 2) ? tx_x2 : tx_x1);
            if (add_enable) begin
               check("add_busy", busy, 1'b1);
               check("add_not_timeout", tx_to, 1'b0);
               check("add_dataa", add_dataa, f_model(tx_x1));
               check("add_datab", add_datab, f_model(tx_x2));
               check("add_en_with_out_valid", out_valid, 1'b0);
               if (!add_seen[c]) begin
                  add_seen[c] = 1'b1; rec_a[c] = add_dataa; rec_b[c] = add_datab;
               end
            end
            if (out_valid) begin
               check("out_valid_busy", busy, 1'b1);
               if (busy) begin
                  check("out_sum", out_sum,
                        tx_to ? QNAN : add_model(f_model(tx_x1), f_model(tx_x2)));
                  check("out_timeout", out_timeout, tx_to);
                  if (!ov_rec[c]) begin
                     ov_rec[c] = 1'b1; t_ov[c] = cyc;
                     rec_sum[c] = out_sum; rec_to[c] = out_timeout;
                  end
               end
            end
            p_in_ready  = in_ready;
            p_out_valid = out_valid;
            p_fn_start  = fn_start;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic keep);
      int n0;
      n0 = n_tx;
      @(negedge clk);
      in_x1 = a; in_x2 = b; in_valid = 1'b1;
      for (int i = 0; i < 600 && n_tx == n0; i++) @(negedge clk);
      if (n_tx == n0) check("accept_bound", 32'd0, 32'd1);
      if (!keep) in_valid = 1'b0;
   endtask

   task automatic wait_out(input int max);
      int i;
      for (i = 0; i < max && !out_valid; i++) @(negedge clk);
      if (!out_valid) check("out_valid_bound", 32'd0, 32'd1);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------- directed sequence ----------------
   initial begin
      int k, ov_cnt, nb;
      reset = 1'b1; in_valid = 1'b0; in_x1 = '0; in_x2 = '0; out_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_fn_data", fn_data, 32'h0);
      check("rst_add_dataa", add_dataa, 32'h0);
      check("rst_add_datab", add_datab, 32'h0);
      check("rst_out_sum", out_sum, 32'h0);
      check("rst_out_timeout", out_timeout, 1'b0);
      check("rst_in_ready", in_ready, 1'b1);
      reset = 1'b0;
      @(negedge clk);
      check("idle_in_ready", in_ready, 1'b1);

      // nominal
      ev_mode = 0; ev_lat = 20; add_lat = 5; next_exp_to = 1'b0;
      send(32'h3F80_0000, 32'h4000_0000, 1'b0);
      k = (n_tx - 1) % 16;
      wait_out(300);
      @(negedge clk);
      check("nom_starts", n_st[k], 2);
      check("nom_fn_data1", d1[k], 32'h3F80_0000);
      check("nom_fn_data2", d2[k], 32'h4000_0000);
      check("nom_dataa", rec_a[k], 32'h4040_0000);
      check("nom_datab", rec_b[k], 32'h40A0_0000);
      check("nom_sum", rec_sum[k], 32'h4100_0000);
      check("nom_timeout", rec_to[k], 1'b0);
      check("nom_start_gap", 32'(t_st1[k] - t_acc[k]), 32'd0);

      // minimum latency: done already qualified at cnt == MIN_LAT everywhere
      ev_lat = 0; add_lat = 0;
      send(32'h4000_0000, 32'h3F80_0000, 1'b0);
      k = (n_tx - 1) % 16;
      wait_out(100);
      @(negedge clk);
      check("min_latency", 32'(t_ov[k] - t_acc[k]), 32'(3 * (MIN_LAT + 1) + 2));

      // stale done: done held high, correct result only from cnt == MIN_LAT
      ev_mode = 1;
      send(32'h3F80_0000, 32'h4120_0000, 1'b0);
      k = (n_tx - 1) % 16;
      wait_out(100);
      @(negedge clk);
      check("stale_f1", rec_a[k], 32'h4040_0000);
      check("stale_latency", 32'(t_ov[k] - t_acc[k]), 32'(3 * (MIN_LAT + 1) + 2));

      // timeout in WAIT1: measured from the edge closing the START1 cycle
      ev_mode = 2; next_exp_to = 1'b1;
      send(32'h4000_0000, 32'h4000_0000, 1'b0);
      k = (n_tx - 1) % 16;
      wait_out(TIMEOUT + 50);
      @(negedge clk);
      check("to_delay", 32'(t_ov[k] - (t_st1[k] + 1)), 32'(TIMEOUT + 1));
      check("to_flag", rec_to[k], 1'b1);
      check("to_sum", rec_sum[k], QNAN);
      check("to_no_add", add_seen[k], 1'b0);
      check("to_starts", n_st[k], 1);

      // done high only before MIN_LAT is never accepted
      ev_mode = 3;
      send(32'h3F80_0000, 32'h4000_0000, 1'b0);
      k = (n_tx - 1) % 16;
      wait_out(TIMEOUT + 50);
      @(negedge clk);
      check("early_done_timeout", rec_to[k], 1'b1);
      check("early_done_no_add", add_seen[k], 1'b0);

      // back-pressure
      ev_mode = 0; ev_lat = 3; add_lat = 2; next_exp_to = 1'b0; out_ready = 1'b0;
      send(32'h4000_0000, 32'h3F80_0000, 1'b0);
      wait_out(100);
      nb = n_tx;
      in_valid = 1'b1; in_x1 = 32'h1234_5678; in_x2 = 32'h9ABC_DEF0;
      repeat (10) @(negedge clk);
      check("bp_valid", out_valid, 1'b1);
      check("bp_sum", out_sum, 32'h40A0_4040);
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_no_accept", n_tx, nb);
      in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      check("bp_valid_fall", out_valid, 1'b0);
      check("bp_ready_after", in_ready, 1'b1);

      // reset in WAIT2
      ev_lat = 20; add_lat = 5;
      send(32'h3F80_0000, 32'h4000_0000, 1'b0);
      k = (n_tx - 1) % 16;
      for (int i = 0; i < 200 && n_st[k] < 2; i++) @(negedge clk);
      check("rst_reach_wait2", n_st[k], 2);
      repeat (5) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("mrst_in_ready", in_ready, 1'b1);
      check("mrst_fn_start", fn_start, 1'b0);
      check("mrst_add_enable", add_enable, 1'b0);
      check("mrst_out_valid", out_valid, 1'b0);
      ov_cnt = 0;
      repeat (40) @(negedge clk) if (out_valid) ov_cnt++;
      check("mrst_no_out", ov_cnt, 0);

      // back-to-back with out_ready tied high
      ev_lat = 2; add_lat = 1; out_ready = 1'b1;
      send(32'h3F80_0000, 32'h4000_0000, 1'b1);
      k = (n_tx - 1) % 16;
      send(32'h4000_0000, 32'h3F80_0000, 1'b0);
      wait_out(100);
      @(negedge clk);
      check("b2b_gap", 32'(t_st1[(k + 1) % 16] - t_ov[k]), 32'd2);
      check("b2b_sum1", rec_sum[k], 32'h4100_0000);
      check("b2b_sum2", rec_sum[(k + 1) % 16], 32'h40A0_4040);

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
